// File: rtl/dff_bank_arbiter.sv
// Two-requester round-robin arbiter in front of a small DFF register bank.
// Optional even-parity storage and checking: define DFF_BANK_PARITY_EN.
module dff_bank_arbiter #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic              perr
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef DFF_BANK_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t state;
    logic   last;
    logic   elig0;
    logic   elig1;

    // The requester being served this cycle sits out the next decision.
    assign elig0 = req0 && (state != G0);
    assign elig1 = req1 && (state != G1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
        end else if (elig0 && elig1) begin
            if (last) begin
                state <= G0;
                last  <= 1'b0;
            end else begin
                state <= G1;
                last  <= 1'b1;
            end
        end else if (elig0) begin
            state <= G0;
            last  <= 1'b0;
        end else if (elig1) begin
            state <= G1;
            last  <= 1'b1;
        end else begin
            state <= IDLE;
        end
    end

    assign gnt0 = (state == G0);
    assign gnt1 = (state == G1);

    logic              act;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_wdata;
    logic [SW-1:0]     wentry;
    logic [SW-1:0]     rentry;
    logic [SW-1:0]     bank [DEPTH];

    assign act       = gnt0 || gnt1;
    assign sel_we    = gnt1 ? we1 : we0;
    assign sel_addr  = gnt1 ? addr1 : addr0;
    assign sel_wdata = gnt1 ? wdata1 : wdata0;
    assign rentry    = bank[sel_addr];

`ifdef DFF_BANK_PARITY_EN
    assign wentry = {^sel_wdata, sel_wdata};
`else
    assign wentry = sel_wdata;
`endif

    // Reset wins over a write granted in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (act && sel_we) begin
            bank[sel_addr] <= wentry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata   <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 && !we0;
            rvalid1 <= gnt1 && !we1;
            if (act && !sel_we) begin
                rdata <= rentry[WIDTH-1:0];
            end
        end
    end

`ifdef DFF_BANK_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perr <= 1'b0;
        end else begin
            perr <= act && !sel_we &&
                    ((^rentry[WIDTH-1:0]) != rentry[WIDTH]);
        end
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter: vector table, hand sequences
// and a read-data scoreboard.
module tb_dff_bank_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, perr;
    logic [7:0] rdata;

    dff_bank_arbiter #(.WIDTH(8), .ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rdata(rdata),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .perr(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       who;
        logic [7:0] data;
    } rd_t;

    typedef struct {
        bit         p;
        bit         we;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    rd_t  q[$];
    rd_t  e;
    logic [7:0] model [4];
    vec_t vecs [12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (rvalid0 || rvalid1)) begin
            if (q.size() == 0) begin
                chk("rvalid_unexpected", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rvalid_who", int'(rvalid1), int'(e.who));
                chk("rdata", int'(rdata), int'(e.data));
            end
            chk("perr", int'(perr), 0);
        end
    end

    task automatic drive(input bit p, input bit r, input bit we,
                         input logic [1:0] a, input logic [7:0] d);
        if (p) begin
            req1 = r; we1 = we; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = we; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic access(input bit p, input bit we, input logic [1:0] a,
                          input logic [7:0] d, input logic [7:0] exp);
        int  lat;
        bit  got;
        rd_t r;
        lat = 0;
        got = 0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, a, d);
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (p ? gnt1 : gnt0) got = 1;
            else lat++;
        end
        chk("gnt_latency", got ? lat : 99, 1);
        if (got && !we) begin
            r.who  = p;
            r.data = exp;
            q.push_back(r);
        end
        @(posedge clk); #1;
        drive(p, 1'b0, we, a, d);
        @(negedge clk);
        if (!we) chk("rvalid_timing", int'(p ? rvalid1 : rvalid0), 1);
    endtask

    task automatic push(input bit p, input logic [7:0] d);
        rd_t r;
        r.who  = p;
        r.data = d;
        q.push_back(r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{0, 0, 2'd0, 8'h00, 8'h00};
        vecs[1]  = '{1, 0, 2'd1, 8'h00, 8'h00};
        vecs[2]  = '{0, 0, 2'd2, 8'h00, 8'h00};
        vecs[3]  = '{1, 0, 2'd3, 8'h00, 8'h00};
        vecs[4]  = '{0, 1, 2'd2, 8'hA5, 8'h00};
        vecs[5]  = '{1, 0, 2'd2, 8'h00, 8'hA5};
        vecs[6]  = '{1, 1, 2'd0, 8'h5A, 8'h00};
        vecs[7]  = '{0, 0, 2'd0, 8'h00, 8'h5A};
        vecs[8]  = '{0, 1, 2'd3, 8'hFF, 8'h00};
        vecs[9]  = '{1, 0, 2'd3, 8'h00, 8'hFF};
        vecs[10] = '{0, 0, 2'd1, 8'h00, 8'h00};
        vecs[11] = '{1, 0, 2'd2, 8'h00, 8'hA5};

        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 2'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 2'd0, 8'h00);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_gnt0", int'(gnt0), 0);
            chk("rst_gnt1", int'(gnt1), 0);
            chk("rst_rvalid", int'(rvalid0 | rvalid1), 0);
            chk("rst_rdata", int'(rdata), 0);
            chk("rst_perr", int'(perr), 0);
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            access(vecs[i].p, vecs[i].we, vecs[i].a,
                   vecs[i].d, vecs[i].exp);
        end

        // Fresh reset so the pointer favours requester 0.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 2'd1, 8'h77);
        drive(1, 1'b1, 1'b0, 2'd1, 8'h00);
        @(negedge clk);
        chk("cont1_idle", int'({gnt1, gnt0}), 0);
        @(negedge clk);
        chk("cont1_first", int'({gnt1, gnt0}), 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("cont1_second", int'({gnt1, gnt0}), 2);
        if (gnt1) push(1, 8'h77);
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        chk("cont1_done", int'({gnt1, gnt0}), 0);

        access(0, 0, 2'd1, 8'h00, 8'h77);

        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 2'd1, 8'h00);
        drive(1, 1'b1, 1'b1, 2'd1, 8'h99);
        @(negedge clk);
        @(negedge clk);
        chk("cont2_first", int'({gnt1, gnt0}), 2);
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        chk("cont2_second", int'({gnt1, gnt0}), 1);
        if (gnt0) push(0, 8'h99);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);

        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 2'd1, 8'h00);
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            chk("held_gnt0", int'(gnt0), i % 2);
            if (gnt0) push(0, 8'h99);
        end
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 2'd1, 8'h3C);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req0  = 1'b0;
        @(negedge clk);
        chk("rstmid_gnt", int'(gnt0), 1);
        @(negedge clk);
        chk("rstmid_abandon", int'(gnt0), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(1, 0, 2'd1, 8'h00, 8'h00);

        for (int i = 0; i < 4; i++) model[i] = 8'h00;
        for (int i = 0; i < 16; i++) begin
            bit         p, we;
            logic [1:0] a;
            logic [7:0] d;
            p  = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = 2'($urandom_range(0, 3));
            d  = 8'($urandom_range(0, 255));
            if (we) model[a] = d;
            access(p, we, a, d, model[a]);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
